// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if
//   Pixel-write bus shared between the pixel producers and plot_arbiter.
//   The producer side (master) presents packed per-requester pixels and the
//   clear command. The arbiter side (slave) returns grants, status, and the
//   single pixel-write port that feeds vga_adapter.
// Signals
//   req, req_x, req_y, req_colour : per-requester pixel offers (packed, i-th slice)
//   gnt                           : combinational one-hot accept
//   clear_start, clear_colour     : full-screen clear command
//   busy, clear_done              : clear sweep status
//   plot_x, plot_y, plot_colour, plot : frame buffer write port
//   oob_err                       : sticky out-of-bounds flag
interface plot_arbiter_if #(
  parameter int NREQ       = 3,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3
);
  logic [NREQ-1:0]            req;
  logic [NREQ*X_BITS-1:0]     req_x;
  logic [NREQ*Y_BITS-1:0]     req_y;
  logic [NREQ*COLOR_BITS-1:0] req_colour;
  logic [NREQ-1:0]            gnt;
  logic                       clear_start;
  logic [COLOR_BITS-1:0]      clear_colour;
  logic                       busy;
  logic                       clear_done;
  logic [X_BITS-1:0]          plot_x;
  logic [Y_BITS-1:0]          plot_y;
  logic [COLOR_BITS-1:0]      plot_colour;
  logic                       plot;
  logic                       oob_err;

  modport master (
    output req, req_x, req_y, req_colour, clear_start, clear_colour,
    input  gnt, busy, clear_done, plot_x, plot_y, plot_colour, plot, oob_err
  );

  modport slave (
    input  req, req_x, req_y, req_colour, clear_start, clear_colour,
    output gnt, busy, clear_done, plot_x, plot_y, plot_colour, plot, oob_err
  );
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Round-robin arbiter that shares the VGA frame buffer pixel-write port
//   among NREQ pixel producers, one pixel per clock, and runs a full-screen
//   clear sweep on command.
// Ports
//   Clck  : system clock, rising edge
//   Reset : asynchronous, active-low reset
//   bus   : plot_arbiter_if.slave (requests, grants, clear control, plot port)
// Configuration
//   PLOT_ARB_BOUNDS_EN : when defined, granted pixels outside the screen are
//   consumed but not plotted and set the sticky oob_err flag. When undefined
//   every granted pixel is forwarded and oob_err is tied low.
module plot_arbiter #(
  parameter int NREQ       = 3,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120
) (
  input logic           Clck,
  input logic           Reset,
  plot_arbiter_if.slave bus
);

  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]            state;
  logic [RR_W-1:0]       rr;
  logic [X_BITS-1:0]     cx;
  logic [Y_BITS-1:0]     cy;
  logic [COLOR_BITS-1:0] clr_colour;

  logic                  plot_q;
  logic [X_BITS-1:0]     plot_x_q;
  logic [Y_BITS-1:0]     plot_y_q;
  logic [COLOR_BITS-1:0] plot_colour_q;
  logic                  busy_q;
  logic                  clear_done_q;

  logic [NREQ-1:0]       gnt_c;
  logic [RR_W-1:0]       gidx;
  logic [RR_W-1:0]       next_rr;
  logic                  found;
  int                    idx;
  logic [X_BITS-1:0]     gx;
  logic [Y_BITS-1:0]     gy;
  logic [COLOR_BITS-1:0] gcol;
  logic                  oob;

  // Round-robin search starting at rr. A clear command, the CLEAR state and
  // reset all suppress grants so no requester thinks it was consumed.
  always_comb begin
    gnt_c = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (Reset && state == ARB && !bus.clear_start) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && bus.req[idx]) begin
          found      = 1'b1;
          gidx       = RR_W'(idx);
          gnt_c[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_rr = (32'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    gx      = bus.req_x[int'(gidx)*X_BITS +: X_BITS];
    gy      = bus.req_y[int'(gidx)*Y_BITS +: Y_BITS];
    gcol    = bus.req_colour[int'(gidx)*COLOR_BITS +: COLOR_BITS];
  end

`ifdef PLOT_ARB_BOUNDS_EN
  logic oob_err_q;

  assign oob = (32'(gx) >= SCR_W) || (32'(gy) >= SCR_H);

  // Sticky until reset; only requester pixels can trip it, never the sweep.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      oob_err_q <= 1'b0;
    end else if (found && oob) begin
      oob_err_q <= 1'b1;
    end
  end

  assign bus.oob_err = oob_err_q;
`else
  assign oob         = 1'b0;
  assign bus.oob_err = 1'b0;
`endif

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      state         <= ARB;
      rr            <= '0;
      cx            <= '0;
      cy            <= '0;
      clr_colour    <= '0;
      plot_q        <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
      busy_q        <= 1'b0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        ARB: begin
          if (bus.clear_start) begin
            state      <= CLEAR;
            cx         <= '0;
            cy         <= '0;
            clr_colour <= bus.clear_colour;
            busy_q     <= 1'b1;
            plot_q     <= 1'b0;
          end else if (found) begin
            rr <= next_rr;
            if (oob) begin
              plot_q <= 1'b0;
            end else begin
              plot_q        <= 1'b1;
              plot_x_q      <= gx;
              plot_y_q      <= gy;
              plot_colour_q <= gcol;
            end
          end else begin
            plot_q <= 1'b0;
          end
        end
        CLEAR: begin
          plot_q        <= 1'b1;
          plot_x_q      <= cx;
          plot_y_q      <= cy;
          plot_colour_q <= clr_colour;
          if (32'(cx) == SCR_W - 1) begin
            cx <= '0;
            if (32'(cy) == SCR_H - 1) begin
              cy           <= '0;
              state        <= ARB;
              busy_q       <= 1'b0;
              clear_done_q <= 1'b1;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.plot        = plot_q;
  assign bus.plot_x      = plot_x_q;
  assign bus.plot_y      = plot_y_q;
  assign bus.plot_colour = plot_colour_q;
  assign bus.busy        = busy_q;
  assign bus.clear_done  = clear_done_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter
//   Directed self-checking bench for plot_arbiter: reset state, single
//   pixel latency, round-robin order, masked requests, full clear sweep,
//   reset during a sweep and out-of-range pixels (PLOT_ARB_BOUNDS_EN aware).
module tb_plot_arbiter;

  localparam int NREQ  = 3;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  plot_arbiter_if #(.NREQ(NREQ)) bus ();

  plot_arbiter #(.NREQ(NREQ)) dut (
    .Clck  (clk),
    .Reset (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [7:0] x,
                                input logic [6:0] y, input logic [2:0] c);
    bus.req_x[i*8 +: 8]      = x;
    bus.req_y[i*7 +: 7]      = y;
    bus.req_colour[i*3 +: 3] = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int dones;
    logic [2:0] exp_g [4];
    tests_run    = 0;
    tests_failed = 0;
    reset_n          = 1'b0;
    bus.req          = 3'b001;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.req_colour   = '0;
    bus.clear_start  = 1'b0;
    bus.clear_colour = '0;
    apply_stimulus(0, 8'd5, 7'd7, 3'b100);

    // reset state, with a request pending
    step();
    step();
    check_output("rst_gnt", 32'(bus.gnt), 32'h0);
    check_output("rst_plot", 32'(bus.plot), 32'h0);
    check_output("rst_busy", 32'(bus.busy), 32'h0);
    check_output("rst_done", 32'(bus.clear_done), 32'h0);
    check_output("rst_oob", 32'(bus.oob_err), 32'h0);
    check_output("rst_xy", {16'h0, bus.plot_x, 1'b0, bus.plot_y}, 32'h0);
    #2 reset_n = 1'b1;

    // single pixel from requester 0
    step();
    check_output("t1_gnt", 32'(bus.gnt), 32'b001);
    step();
    bus.req = 3'b000;
    check_output("t1_plot", 32'(bus.plot), 32'h1);
    check_output("t1_x", 32'(bus.plot_x), 32'd5);
    check_output("t1_y", 32'(bus.plot_y), 32'd7);
    check_output("t1_c", 32'(bus.plot_colour), 32'b100);
    step();
    check_output("t1_idle", 32'(bus.plot), 32'h0);
    check_output("t1_hold_x", 32'(bus.plot_x), 32'd5);

    // reset pulse brings rr back to 0
    #2 reset_n = 1'b0;
    #1 check_output("rst2_plot", 32'(bus.plot), 32'h0);
    #1 reset_n = 1'b1;

    // all three requesting: 0,1,2,0,1,2
    for (int i = 0; i < NREQ; i++)
      apply_stimulus(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    step();
    bus.req = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      check_output("t2_gnt", 32'(bus.gnt), 32'(3'b001 << (k % 3)));
      step();
      check_output("t2_plot", 32'(bus.plot), 32'h1);
      check_output("t2_x", 32'(bus.plot_x), 32'(10 + (k % 3)));
      check_output("t2_c", 32'(bus.plot_colour), 32'((k % 3) + 1));
    end

    // requesters 0 and 2 only, rr back at 0 so 0,2,0,2
    bus.req = 3'b101;
    exp_g[0] = 3'b001; exp_g[1] = 3'b100; exp_g[2] = 3'b001; exp_g[3] = 3'b100;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output("t3_gnt", 32'(bus.gnt), 32'(exp_g[k]));
      step();
      check_output("t3_y", 32'(bus.plot_y), (k % 2 == 0) ? 32'd20 : 32'd22);
    end
    bus.req = 3'b000;
    step();
    check_output("t3_idle", 32'(bus.plot), 32'h0);

    // clear sweep while requester 1 waits
    apply_stimulus(1, 8'd33, 7'd44, 3'b101);
    bus.req          = 3'b010;
    bus.clear_start  = 1'b1;
    bus.clear_colour = 3'b010;
    #1 check_output("t4_gnt_start", 32'(bus.gnt), 32'h0);
    step();
    bus.clear_start  = 1'b0;
    bus.clear_colour = 3'b111;
    check_output("t4_busy", 32'(bus.busy), 32'h1);
    check_output("t4_plot0", 32'(bus.plot), 32'h0);
    bad   = 0;
    dones = 0;
    for (int n = 0; n < SCR_W * SCR_H; n++) begin
      step();
      if (bus.clear_done) dones++;
      if (bus.plot !== 1'b1 || 32'(bus.plot_x) != n % SCR_W ||
          32'(bus.plot_y) != n / SCR_W || bus.plot_colour !== 3'b010) bad++;
      if (n < SCR_W * SCR_H - 1 && (bus.gnt !== 3'b000 || bus.busy !== 1'b1)) bad++;
    end
    check_output("t4_sweep_bad", 32'(bad), 32'h0);
    check_output("t4_last_x", 32'(bus.plot_x), 32'd159);
    check_output("t4_last_y", 32'(bus.plot_y), 32'd119);
    check_output("t4_done", 32'(bus.clear_done), 32'h1);
    check_output("t4_busy_end", 32'(bus.busy), 32'h0);
    check_output("t4_gnt_after", 32'(bus.gnt), 32'b010);
    step();
    bus.req = 3'b000;
    check_output("t4_done_pulse", 32'(bus.clear_done), 32'h0);
    check_output("t4_done_count", 32'(dones), 32'h1);
    check_output("t4_req1_x", 32'(bus.plot_x), 32'd33);
    check_output("t4_req1_plot", 32'(bus.plot), 32'h1);

    // reset at sweep pixel 500
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    for (int n = 0; n < 500; n++) step();
    check_output("t5_busy_pre", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_output("t5_plot", 32'(bus.plot), 32'h0);
    check_output("t5_busy", 32'(bus.busy), 32'h0);
    step();
    #2 reset_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (bus.clear_done || bus.busy || bus.plot) dones++;
    end
    check_output("t5_quiet", 32'(dones), 32'h0);
    bus.req = 3'b001;
    apply_stimulus(0, 8'd1, 7'd2, 3'b011);
    #1 check_output("t5_arb_gnt", 32'(bus.gnt), 32'b001);
    step();
    check_output("t5_arb_plot", 32'(bus.plot), 32'h1);

    // out-of-range pixel from requester 0 (rr is 1 here, only req0 asks)
    apply_stimulus(0, 8'd160, 7'd0, 3'b111);
    #1 check_output("t6_gnt", 32'(bus.gnt), 32'b001);
    step();
    bus.req = 3'b000;
`ifdef PLOT_ARB_BOUNDS_EN
    check_output("t6_plot", 32'(bus.plot), 32'h0);
    check_output("t6_oob", 32'(bus.oob_err), 32'h1);
    bus.req = 3'b001;
    apply_stimulus(0, 8'd3, 7'd4, 3'b001);
    step();
    bus.req = 3'b000;
    check_output("t6_plot_ok", 32'(bus.plot), 32'h1);
    check_output("t6_oob_sticky", 32'(bus.oob_err), 32'h1);
`else
    check_output("t6_plot", 32'(bus.plot), 32'h1);
    check_output("t6_x", 32'(bus.plot_x), 32'd160);
    check_output("t6_oob", 32'(bus.oob_err), 32'h0);
`endif
    step();
    check_output("t6_idle", 32'(bus.plot), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
